mem_stage_sram: RTL and testbench

Memory stage of the 5-stage ARM-subset pipeline, directly downstream of the execute stage and its EXE/MEM register. Consumes the registered control bits, destination, ALU result (the effective address) and store data. Performs loads/stores against an external 16-bit asynchronous SRAM through a multi-cycle FSM, stalling the whole pipeline with `freeze` while busy. Registers results into the MEM/WB register.

---
 rtl/mem_stage_sram_pkg.sv | 34 +++
 rtl/mem_stage_sram_mem_wb_reg.sv | 31 +++
 rtl/mem_stage_sram.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage_sram.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg: shared types and constants for the memory stage.
// Holds the SRAM access FSM state encoding, default data base address,
// datapath widths, the MEM/WB register bundle and a halfword address helper.
package mem_stage_sram_pkg;

    localparam int DATA_BASE_DEFAULT = 1024;
    localparam int REG_ADDR_W        = 4;
    localparam int WORD_W            = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic                  wb_enable;
        logic                  mem_read_enable;
        logic [REG_ADDR_W-1:0] dest;
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     mem_data;
    } mem_wb_t;

    // Byte offset of an effective address from the SRAM window base.
    // Addresses below the base simply wrap.
    function automatic logic [WORD_W-1:0] window_offset(
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/mem_stage_sram_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with synchronous reset and freeze hold.
// Ports: clk, rst, freeze (hold), data_load (update mem_data), stage (next
// bundle), mem_wb (registered bundle).
module mem_wb_reg
    import mem_stage_sram_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    freeze,
    input  logic    data_load,
    input  mem_wb_t stage,
    output mem_wb_t mem_wb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb <= '0;
        end else if (!freeze) begin
            mem_wb.wb_enable       <= stage.wb_enable;
            mem_wb.mem_read_enable <= stage.mem_read_enable;
            mem_wb.dest            <= stage.dest;
            mem_wb.alu_result      <= stage.alu_result;
            // Load data is only replaced by an actual load; other
            // instructions leave the last loaded word in place.
            if (data_load) begin
                mem_wb.mem_data <= stage.mem_data;
            end
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: memory stage driving a 16-bit asynchronous SRAM with a
// multi-cycle IDLE/LO/HI/DONE FSM; stalls the pipeline via freeze while busy.
// Ports: clk, rst (sync, active high); EXE/MEM inputs (wb/read/write enables,
// dest_in, alu_result_in, val_rm_in); freeze; MEM/WB outputs; SRAM pins
// (sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n); misalign_err.
// Optional feature macro: MEM_ALIGN_CHECK_EN (alignment check, sticky error).
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int DATA_BASE = DATA_BASE_DEFAULT,
    parameter int SRAM_AW   = 18,
    parameter int SRAM_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_enable_in,
    input  logic                  mem_read_enable_in,
    input  logic                  mem_write_enable_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [WORD_W-1:0]     alu_result_in,
    input  logic [WORD_W-1:0]     val_rm_in,
    output logic                  freeze,
    output logic                  wb_enable_out,
    output logic                  mem_read_enable_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [WORD_W-1:0]     alu_result_out,
    output logic [WORD_W-1:0]     mem_data_out,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_we_n,
    output logic                  misalign_err
);

    // The cycle in which a request is first seen in IDLE already drives
    // the low half, so the LO state itself only covers the remaining
    // SRAM_WAIT cycles of that phase. With no wait states the low half
    // is complete in that first cycle and the FSM goes straight to HI.
    localparam logic [2:0] HI_END = 3'(SRAM_WAIT);
    localparam logic [2:0] LO_END =
        (SRAM_WAIT == 0) ? 3'd0 : 3'(SRAM_WAIT - 1);
    localparam bit HOLD_EDGE = (SRAM_WAIT != 0);

    mem_state_t state;
    logic [2:0] cnt;
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;

    logic req;
    logic wr;
    logic load;
    logic mis;
    logic idle_req;
    logic lo_phase;
    logic hi_phase;
    logic lo_last;
    logic hi_last;
    logic last;

    logic [WORD_W-1:0]  off;
    logic [SRAM_AW-1:0] hw;
    logic [SRAM_AW-1:0] lo_addr;
    logic [SRAM_AW-1:0] hi_addr;
    logic               unused_bits;

    mem_wb_t stage;
    mem_wb_t mem_wb;

    assign req  = mem_read_enable_in | mem_write_enable_in;
    assign wr   = mem_write_enable_in;
    assign load = mem_read_enable_in & ~mem_write_enable_in;

    assign off     = window_offset(alu_result_in, WORD_W'(DATA_BASE));
    assign hw      = off[SRAM_AW:1];
    assign lo_addr = {hw[SRAM_AW-1:1], 1'b0};
    assign hi_addr = {hw[SRAM_AW-1:1], 1'b1};

    assign unused_bits = ^{off[WORD_W-1:SRAM_AW+1], off[0], hw[0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = req & (|alu_result_in[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign idle_req = (state == IDLE) & req;
    assign lo_phase = idle_req | (state == LO);
    assign hi_phase = (state == HI);

    assign lo_last = (SRAM_WAIT == 0) ? idle_req
                   : ((state == LO) && (cnt == LO_END));
    assign hi_last = hi_phase && (cnt == HI_END);
    assign last    = lo_last | hi_last;

    assign freeze = lo_phase | hi_phase;

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (lo_phase) begin
            sram_addr = lo_addr;
            if (wr) begin
                sram_dq_out = val_rm_in[15:0];
                sram_dq_oe  = 1'b1;
                // Release we_n on the last cycle so data is held
                // across the rising edge of the strobe.
                sram_we_n   = mis | (HOLD_EDGE & last);
            end
        end else if (hi_phase) begin
            sram_addr = hi_addr;
            if (wr) begin
                sram_dq_out = val_rm_in[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = mis | (HOLD_EDGE & last);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd_lo <= '0;
            rd_hi <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= (SRAM_WAIT == 0) ? HI : LO;
                        cnt   <= '0;
                    end
                end
                LO: begin
                    if (cnt == LO_END) begin
                        state <= HI;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                HI: begin
                    if (cnt == HI_END) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
            if (lo_last) begin
                rd_lo <= sram_dq_in;
            end
            if (hi_last) begin
                rd_hi <= sram_dq_in;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (mis) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign stage.wb_enable       = wb_enable_in;
    assign stage.mem_read_enable = mem_read_enable_in;
    assign stage.dest            = dest_in;
    assign stage.alu_result      = alu_result_in;
    assign stage.mem_data        = mis ? '0 : {rd_hi, rd_lo};

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .data_load (load),
        .stage     (stage),
        .mem_wb    (mem_wb)
    );

    assign wb_enable_out       = mem_wb.wb_enable;
    assign mem_read_enable_out = mem_wb.mem_read_enable;
    assign dest_out            = mem_wb.dest;
    assign alu_result_out      = mem_wb.alu_result;
    assign mem_data_out        = mem_wb.mem_data;

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: directed bench for mem_stage_sram with an SRAM model.
// Table-driven accesses plus hand sequences for waveform, reset and alignment.
module tb_mem_stage_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable_in;
    logic        mem_read_enable_in;
    logic        mem_write_enable_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] val_rm_in;
    logic        freeze;
    logic        wb_enable_out;
    logic        mem_read_enable_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    int we_low = 0;

    logic [15:0] sram [0:262143];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sram_addr] <= sram_dq_out;
            we_low <= we_low + 1;
        end
    end

    assign sram_dq_in = sram[sram_addr];

    mem_stage_sram dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_enable_in        (wb_enable_in),
        .mem_read_enable_in  (mem_read_enable_in),
        .mem_write_enable_in (mem_write_enable_in),
        .dest_in             (dest_in),
        .alu_result_in       (alu_result_in),
        .val_rm_in           (val_rm_in),
        .freeze              (freeze),
        .wb_enable_out       (wb_enable_out),
        .mem_read_enable_out (mem_read_enable_out),
        .dest_out            (dest_out),
        .alu_result_out      (alu_result_out),
        .mem_data_out        (mem_data_out),
        .sram_addr           (sram_addr),
        .sram_dq_out         (sram_dq_out),
        .sram_dq_oe          (sram_dq_oe),
        .sram_dq_in          (sram_dq_in),
        .sram_we_n           (sram_we_n),
        .misalign_err        (misalign_err)
    );

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [31:0] nf;
        logic [17:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(
        input logic wb, input logic rd, input logic wr,
        input logic [3:0] dest, input logic [31:0] alu,
        input logic [31:0] rm, input logic [31:0] nf,
        input logic [17:0] addr, input logic [31:0] data
    );
        vec_t v;
        v.wb = wb; v.rd = rd; v.wr = wr; v.dest = dest;
        v.alu = alu; v.rm = rm; v.nf = nf; v.addr = addr;
        v.data = data;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_enable_in        = v.wb;
        mem_read_enable_in  = v.rd;
        mem_write_enable_in = v.wr;
        dest_in             = v.dest;
        alu_result_in       = v.alu;
        val_rm_in           = v.rm;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 4'd0, 32'd0, 32'd0, 0, 18'd0, 32'd0));
    endtask

    // Present one instruction, count frozen cycles (bounded), then check
    // the MEM/WB register after the capturing edge.
    task automatic apply(input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        #1;
        chk("first_addr", 32'(sram_addr), 32'(v.addr));
        n = 0;
        while (freeze === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("freeze_cycles", n, v.nf);
        @(posedge clk);
        #1;
        chk("wb_out", 32'(wb_enable_out), 32'(v.wb));
        chk("mrd_out", 32'(mem_read_enable_out), 32'(v.rd));
        chk("dest_out", 32'(dest_out), 32'(v.dest));
        chk("alu_out", alu_result_out, v.alu);
        chk("mem_data", mem_data_out, v.data);
    endtask

    logic [17:0] w_addr [5];
    logic [15:0] w_dq   [5];
    logic        w_we   [5];
    logic        w_oe   [5];
    logic        w_fz   [5];

    initial begin
        int wl;
        rst = 1'b1;
        idle_inputs();

        vecs[0]  = mk(1, 0, 0, 4'd3,  32'h1234,     32'h0,        0, 18'h0,     32'h0);
        vecs[1]  = mk(0, 0, 0, 4'd7,  32'hFFFFFFFF, 32'h0,        0, 18'h0,     32'h0);
        vecs[2]  = mk(0, 0, 1, 4'd0,  32'd1032,     32'hDEADBEEF, 4, 18'd4,     32'h0);
        vecs[3]  = mk(1, 1, 0, 4'd5,  32'd1032,     32'h0,        4, 18'd4,     32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 1, 4'd0,  32'd1024,     32'h01234567, 4, 18'd0,     32'hDEADBEEF);
        vecs[5]  = mk(0, 0, 1, 4'd0,  32'd1028,     32'h89ABCDEF, 4, 18'd2,     32'hDEADBEEF);
        vecs[6]  = mk(1, 1, 0, 4'd1,  32'd1024,     32'h0,        4, 18'd0,     32'h01234567);
        vecs[7]  = mk(1, 1, 0, 4'd2,  32'd1028,     32'h0,        4, 18'd2,     32'h89ABCDEF);
        vecs[8]  = mk(0, 1, 1, 4'd4,  32'd1036,     32'h55AA33CC, 4, 18'd6,     32'h89ABCDEF);
        vecs[9]  = mk(1, 1, 0, 4'd6,  32'd1036,     32'h0,        4, 18'd6,     32'h55AA33CC);
        vecs[10] = mk(0, 0, 1, 4'd0,  32'd1020,     32'hCAFEF00D, 4, 18'h3FFFE, 32'h55AA33CC);
        vecs[11] = mk(1, 1, 0, 4'd8,  32'd1020,     32'h0,        4, 18'h3FFFE, 32'hCAFEF00D);
        vecs[12] = mk(1, 0, 0, 4'd15, 32'h0BADF00D, 32'h0,        0, 18'h0,     32'hCAFEF00D);

        w_addr = '{18'd8, 18'd8, 18'd9, 18'd9, 18'd0};
        w_dq   = '{16'h2222, 16'h2222, 16'h1111, 16'h1111, 16'h0};
        w_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        w_oe   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        w_fz   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_wb", 32'(wb_enable_out), 32'd0);
        chk("rst_mrd", 32'(mem_read_enable_out), 32'd0);
        chk("rst_dest", 32'(dest_out), 32'd0);
        chk("rst_alu", alu_result_out, 32'd0);
        chk("rst_data", mem_data_out, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
        end

        // Store waveform at 1040: halfwords 8 and 9, one strobe each
        @(negedge clk);
        wl = we_low;
        drive(mk(0, 0, 1, 4'd0, 32'd1040, 32'h11112222, 0, 18'd0, 32'd0));
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("wv_addr", 32'(sram_addr), 32'(w_addr[c]));
            chk("wv_dq", 32'(sram_dq_out), 32'(w_dq[c]));
            chk("wv_we_n", 32'(sram_we_n), 32'(w_we[c]));
            chk("wv_oe", 32'(sram_dq_oe), 32'(w_oe[c]));
            chk("wv_freeze", 32'(freeze), 32'(w_fz[c]));
            @(negedge clk);
        end
        chk("wv_strobes", we_low - wl, 2);
        idle_inputs();
        apply(mk(1, 1, 0, 4'd9, 32'd1040, 32'h0, 4, 18'd8, 32'h11112222));

        // Reset during the HI phase of a store
        @(negedge clk);
        drive(mk(0, 0, 1, 4'd0, 32'd1048, 32'h77778888, 0, 18'd0, 32'd0));
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("hi_addr", 32'(sram_addr), 32'd13);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("ab_freeze", 32'(freeze), 32'd0);
        chk("ab_we_n", 32'(sram_we_n), 32'd1);
        chk("ab_oe", 32'(sram_dq_oe), 32'd0);
        chk("ab_addr", 32'(sram_addr), 32'd0);
        chk("ab_data", mem_data_out, 32'd0);
        chk("ab_wb", 32'(wb_enable_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 0, 0, 4'd2, 32'h42, 32'h0, 0, 18'd0, 32'h0));

`ifdef MEM_ALIGN_CHECK_EN
        wl = we_low;
        apply(mk(0, 0, 1, 4'd0, 32'd1026, 32'hAAAA5555, 4, 18'd0, 32'h0));
        chk("mis_strobes", we_low - wl, 0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        apply(mk(1, 1, 0, 4'd3, 32'd1030, 32'h0, 4, 18'd2, 32'h0));
        apply(mk(1, 1, 0, 4'd3, 32'd1028, 32'h0, 4, 18'd2, 32'h89ABCDEF));
        chk("mis_sticky", 32'(misalign_err), 32'd1);
`else
        apply(mk(1, 1, 0, 4'd3, 32'd1030, 32'h0, 4, 18'd2, 32'h89ABCDEF));
        chk("no_mis_err", 32'(misalign_err), 32'd0);
`endif

        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
